// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default depth, Gray/binary conversions, FWFT output states.
// Conversions work on a zero-extended wide word, so one function serves any pointer width.
package fifo_pkg;

  localparam int ADDRESS_WIDTH_DEF = 4;
  localparam int GRAY_MAX_W        = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } out_state_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero bits above the real width leave the prefix XOR unaffected.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fwft_out_reg.sv
// First-word-fall-through holding register with valid/ready handshake.
// A pop loads (or refills on a same-cycle accept); an accept without pop empties it.
module fwft_out_reg
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] RD_data,
  input  logic                  OUT_ready,
  output logic [DATA_WIDTH-1:0] OUT_data,
  output logic                  OUT_valid
);

  out_state_t            state_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= HOLD_EMPTY;
      data_reg  <= '0;
    end else if (pop) begin
      data_reg  <= RD_data;
      state_reg <= HOLD_FULL;
    end else if (OUT_ready) begin
      state_reg <= HOLD_EMPTY;
    end
  end

  assign OUT_data  = data_reg;
  assign OUT_valid = (state_reg == HOLD_FULL);

endmodule

// File: rtl/rd_empty_fwft.sv
// Read-side controller of the asynchronous FIFO: read pointer, EMPTY/LEVEL/ALMOST_EMPTY
// flags, and an FWFT output stage fed from the memory read port.
module rd_empty_fwft
  import fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = 8,
  parameter int AE_THRESH     = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [ADDRESS_WIDTH:0]   Rq2_Wptr,
  input  logic [DATA_WIDTH-1:0]    RD_data,
  output logic [ADDRESS_WIDTH-1:0] R_addr,
  output logic [ADDRESS_WIDTH:0]   R_ptr,
  output logic                     EMPTY,
  output logic [ADDRESS_WIDTH:0]   LEVEL,
  output logic                     ALMOST_EMPTY,
  output logic [DATA_WIDTH-1:0]    OUT_data,
  output logic                     OUT_valid,
  input  logic                     OUT_ready
);

  localparam int PW = ADDRESS_WIDTH + 1;

  logic [PW-1:0] bin_ptr_reg;
  logic [PW-1:0] gray_ptr_reg;
  logic          empty_reg;
  logic [PW-1:0] level_reg;
  logic          ae_reg;

  logic          pop;
  logic [PW-1:0] bin_ptr_next;
  logic [PW-1:0] gray_ptr_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] level_next;

  assign pop           = !empty_reg && (!OUT_valid || OUT_ready);
  assign bin_ptr_next  = bin_ptr_reg + PW'(pop);
  assign gray_ptr_next = PW'(bin2gray(GRAY_MAX_W'(bin_ptr_next)));
  assign wbin          = PW'(gray2bin(GRAY_MAX_W'(Rq2_Wptr)));
  // Flags look at the post-pop pointer so popping the last word raises EMPTY at once.
  assign level_next    = wbin - bin_ptr_next;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bin_ptr_reg  <= '0;
      gray_ptr_reg <= '0;
      empty_reg    <= 1'b1;
      level_reg    <= '0;
      ae_reg       <= 1'b1;
    end else begin
      bin_ptr_reg  <= bin_ptr_next;
      gray_ptr_reg <= gray_ptr_next;
      empty_reg    <= (gray_ptr_next == Rq2_Wptr);
      level_reg    <= level_next;
      ae_reg       <= (level_next <= PW'(AE_THRESH));
    end
  end

  fwft_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out (
    .CLK      (CLK),
    .RST      (RST),
    .pop      (pop),
    .RD_data  (RD_data),
    .OUT_ready(OUT_ready),
    .OUT_data (OUT_data),
    .OUT_valid(OUT_valid)
  );

  assign R_addr       = bin_ptr_reg[ADDRESS_WIDTH-1:0];
  assign R_ptr        = gray_ptr_reg;
  assign EMPTY        = empty_reg;
  assign LEVEL        = level_reg;
  assign ALMOST_EMPTY = ae_reg;

endmodule

// File: tb/tb_rd_empty_fwft.sv
// Directed bench for rd_empty_fwft: reset, single word, backpressure, full depth, wrap, mid-stream reset.
module tb_rd_empty_fwft;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] Rq2_Wptr;
  logic [7:0] RD_data;
  logic [3:0] R_addr;
  logic [4:0] R_ptr;
  logic       EMPTY;
  logic [4:0] LEVEL;
  logic       ALMOST_EMPTY;
  logic [7:0] OUT_data;
  logic       OUT_valid;
  logic       OUT_ready;

  logic [7:0] mem [16];
  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;
  assign RD_data = mem[R_addr];

  rd_empty_fwft #(.ADDRESS_WIDTH(4), .DATA_WIDTH(8), .AE_THRESH(2)) dut (
    .CLK(CLK), .RST(RST), .Rq2_Wptr(Rq2_Wptr), .RD_data(RD_data),
    .R_addr(R_addr), .R_ptr(R_ptr), .EMPTY(EMPTY), .LEVEL(LEVEL),
    .ALMOST_EMPTY(ALMOST_EMPTY), .OUT_data(OUT_data), .OUT_valid(OUT_valid),
    .OUT_ready(OUT_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    Rq2_Wptr = 5'b00000;
    OUT_ready = 1'b0;
    tick();
    tick();
    RST = 1'b1;
  endtask

  initial begin
    mem[0] = 8'hA5;
    for (int i = 1; i < 16; i++) mem[i] = 8'(8'h30 + i * 7);
    RST = 1'b1;
    Rq2_Wptr = 5'b00000;
    OUT_ready = 1'b0;

    // asynchronous reset before any clock edge
    #3 RST = 1'b0;
    #1;
    chk("rst_empty", 32'(EMPTY), 1);
    chk("rst_ae", 32'(ALMOST_EMPTY), 1);
    chk("rst_level", 32'(LEVEL), 0);
    chk("rst_rptr", 32'(R_ptr), 0);
    chk("rst_raddr", 32'(R_addr), 0);
    chk("rst_valid", 32'(OUT_valid), 0);
    tick();
    RST = 1'b1;
    tick();
    chk("idle_empty", 32'(EMPTY), 1);
    $display("reset: EMPTY=%0d LEVEL=%0d", EMPTY, LEVEL);

    // single word
    OUT_ready = 1'b1;
    Rq2_Wptr = 5'b00001;
    tick();
    chk("sw_empty0", 32'(EMPTY), 0);
    chk("sw_level1", 32'(LEVEL), 1);
    chk("sw_valid0", 32'(OUT_valid), 0);
    tick();
    chk("sw_valid1", 32'(OUT_valid), 1);
    chk("sw_data", 32'(OUT_data), 32'h A5);
    chk("sw_rptr", 32'(R_ptr), 5'b00001);
    chk("sw_empty1", 32'(EMPTY), 1);
    chk("sw_level0", 32'(LEVEL), 0);
    $display("single: OUT_data=%0h R_ptr=%b", OUT_data, R_ptr);
    tick();
    chk("sw_drain", 32'(OUT_valid), 0);

    // backpressure
    do_reset();
    Rq2_Wptr = 5'b00010;
    tick();
    chk("bp_level3", 32'(LEVEL), 3);
    chk("bp_empty", 32'(EMPTY), 0);
    tick();
    chk("bp_load_valid", 32'(OUT_valid), 1);
    chk("bp_load_data", 32'(OUT_data), 32'(mem[0]));
    chk("bp_raddr", 32'(R_addr), 1);
    chk("bp_level2", 32'(LEVEL), 2);
    tick();
    chk("bp_hold_raddr", 32'(R_addr), 1);
    chk("bp_hold_data", 32'(OUT_data), 32'(mem[0]));
    chk("bp_hold_level", 32'(LEVEL), 2);
    OUT_ready = 1'b1;
    tick();
    chk("bp_w1_data", 32'(OUT_data), 32'(mem[1]));
    chk("bp_w1_raddr", 32'(R_addr), 2);
    chk("bp_w1_level", 32'(LEVEL), 1);
    tick();
    chk("bp_w2_data", 32'(OUT_data), 32'(mem[2]));
    chk("bp_w2_valid", 32'(OUT_valid), 1);
    chk("bp_w2_empty", 32'(EMPTY), 1);
    chk("bp_w2_raddr", 32'(R_addr), 3);
    tick();
    chk("bp_done_valid", 32'(OUT_valid), 0);
    $display("backpressure: R_addr=%0d LEVEL=%0d", R_addr, LEVEL);

    // full depth
    do_reset();
    Rq2_Wptr = 5'b11000;
    tick();
    chk("fd_level16", 32'(LEVEL), 16);
    chk("fd_ae0", 32'(ALMOST_EMPTY), 0);
    chk("fd_empty0", 32'(EMPTY), 0);
    OUT_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("fd_data", 32'(OUT_data), 32'(mem[k-1]));
      chk("fd_valid", 32'(OUT_valid), 1);
      chk("fd_level", 32'(LEVEL), 32'(16 - k));
      chk("fd_ae", 32'(ALMOST_EMPTY), (16 - k <= 2) ? 1 : 0);
      chk("fd_empty", 32'(EMPTY), (k == 16) ? 1 : 0);
      $display("full drain %0d: OUT_data=%0h LEVEL=%0d AE=%0d", k, OUT_data, LEVEL, ALMOST_EMPTY);
    end
    chk("fd_rptr", 32'(R_ptr), 5'b11000);
    tick();
    chk("fd_done_valid", 32'(OUT_valid), 0);

    // wrap: advance read pointer from 16 to 30
    Rq2_Wptr = 5'b10001;
    for (int k = 0; k < 16; k++) tick();
    chk("wr_pre_raddr", 32'(R_addr), 14);
    chk("wr_pre_rptr", 32'(R_ptr), 5'b10001);
    chk("wr_pre_empty", 32'(EMPTY), 1);
    chk("wr_pre_valid", 32'(OUT_valid), 0);
    Rq2_Wptr = 5'b00011;
    tick();
    chk("wr_level4", 32'(LEVEL), 4);
    chk("wr_raddr14", 32'(R_addr), 14);
    tick();
    chk("wr_raddr15", 32'(R_addr), 15);
    chk("wr_rptr31", 32'(R_ptr), 5'b10000);
    chk("wr_data14", 32'(OUT_data), 32'(mem[14]));
    tick();
    chk("wr_raddr0", 32'(R_addr), 0);
    chk("wr_rptr0", 32'(R_ptr), 5'b00000);
    chk("wr_level2", 32'(LEVEL), 2);
    chk("wr_ae", 32'(ALMOST_EMPTY), 1);
    tick();
    chk("wr_raddr1", 32'(R_addr), 1);
    chk("wr_data0", 32'(OUT_data), 32'(mem[0]));
    tick();
    chk("wr_empty", 32'(EMPTY), 1);
    chk("wr_raddr2", 32'(R_addr), 2);
    chk("wr_rptr2", 32'(R_ptr), 5'b00011);
    chk("wr_data1", 32'(OUT_data), 32'(mem[1]));
    $display("wrap: R_addr=%0d R_ptr=%b EMPTY=%0d", R_addr, R_ptr, EMPTY);

    // reset mid-stream
    do_reset();
    Rq2_Wptr = 5'b00101;
    tick();
    tick();
    chk("ms_valid", 32'(OUT_valid), 1);
    chk("ms_level5", 32'(LEVEL), 5);
    #2 RST = 1'b0;
    Rq2_Wptr = 5'b00000;
    #1;
    chk("ms_rst_empty", 32'(EMPTY), 1);
    chk("ms_rst_ae", 32'(ALMOST_EMPTY), 1);
    chk("ms_rst_level", 32'(LEVEL), 0);
    chk("ms_rst_rptr", 32'(R_ptr), 0);
    chk("ms_rst_raddr", 32'(R_addr), 0);
    chk("ms_rst_valid", 32'(OUT_valid), 0);
    chk("ms_rst_data", 32'(OUT_data), 0);
    tick();
    RST = 1'b1;
    OUT_ready = 1'b1;
    tick();
    tick();
    chk("ms_post_empty", 32'(EMPTY), 1);
    chk("ms_post_valid", 32'(OUT_valid), 0);
    chk("ms_post_level", 32'(LEVEL), 0);
    chk("ms_post_raddr", 32'(R_addr), 0);
    $display("mid-stream reset: EMPTY=%0d OUT_valid=%0d", EMPTY, OUT_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
